// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXE/MEM/WB with
// instruction/data memory ready handshakes and counts retired instructions.
// Note: rst_n keeps its legacy name but is an ACTIVE-HIGH asynchronous reset.
module mc_ctrl #(
   parameter int unsigned ALUOP_W   = 3,
   parameter bit          ENABLE_JR = 1'b1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         OP,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               PCWr,
   output logic               IRWr,
   output logic               RFWr,
   output logic               DMWr,
   output logic               DMRd,
   output logic               BSel,
   output logic [1:0]         WDSel,
   output logic [1:0]         GPRSel,
   output logic [1:0]         NPCOp,
   output logic [1:0]         EXTOp,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [2:0]         state,
   output logic               instr_done,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_cnt
);

   // FSM state encodings (visible on the state port)
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXE    = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   // ALU operations
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

   // Datapath select encodings
   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_DM    = 2'b01;
   localparam logic [1:0] WD_PC4   = 2'b10;
   localparam logic [1:0] GPR_RD   = 2'b00;
   localparam logic [1:0] GPR_RT   = 2'b01;
   localparam logic [1:0] GPR_RA   = 2'b10;
   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_J    = 2'b10;
   localparam logic [1:0] NPC_JR   = 2'b11;
   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;

   logic [2:0]         state_nxt;
   logic               is_rtype;
   logic               is_jr;
   logic               is_ori;
   logic               is_addi;
   logic               is_lw;
   logic               is_sw;
   logic               is_beq;
   logic               is_jal;
   logic               is_ill;
   logic [ALUOP_W-1:0] alu_dec;
   logic [1:0]         ext_dec;
   logic               bsel_dec;
   logic [1:0]         gpr_dec;
   logic [1:0]         wd_dec;

   // Instruction class and the selects held for the whole instruction
   always_comb begin
      is_rtype = 1'b0;
      is_jr    = 1'b0;
      is_ori   = 1'b0;
      is_addi  = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_beq   = 1'b0;
      is_jal   = 1'b0;
      alu_dec  = ALU_ADD;
      ext_dec  = EXT_ZERO;
      bsel_dec = 1'b0;
      gpr_dec  = GPR_RD;
      wd_dec   = WD_ALU;
      case (OP)
         OP_RTYPE: begin
            case (Funct)
               FN_ADDU: begin is_rtype = 1'b1; alu_dec = ALU_ADD; end
               FN_SUBU: begin is_rtype = 1'b1; alu_dec = ALU_SUB; end
               FN_OR:   begin is_rtype = 1'b1; alu_dec = ALU_OR;  end
               FN_AND:  begin is_rtype = 1'b1; alu_dec = ALU_AND; end
               FN_SLT:  begin is_rtype = 1'b1; alu_dec = ALU_SLT; end
               FN_JR:   is_jr = ENABLE_JR;
               default: ;
            endcase
            if (is_rtype) begin
               gpr_dec = GPR_RD;
               wd_dec  = WD_ALU;
            end
         end
         OP_ORI: begin
            is_ori   = 1'b1;
            alu_dec  = ALU_OR;
            ext_dec  = EXT_ZERO;
            bsel_dec = 1'b1;
            gpr_dec  = GPR_RT;
         end
         OP_ADDI: begin
            is_addi  = 1'b1;
            alu_dec  = ALU_ADD;
            ext_dec  = EXT_SIGN;
            bsel_dec = 1'b1;
            gpr_dec  = GPR_RT;
         end
         OP_LW: begin
            is_lw    = 1'b1;
            alu_dec  = ALU_ADD;
            ext_dec  = EXT_SIGN;
            bsel_dec = 1'b1;
            gpr_dec  = GPR_RT;
            wd_dec   = WD_DM;
         end
         OP_SW: begin
            is_sw    = 1'b1;
            alu_dec  = ALU_ADD;
            ext_dec  = EXT_SIGN;
            bsel_dec = 1'b1;
         end
         OP_BEQ: begin
            is_beq   = 1'b1;
            alu_dec  = ALU_SUB;
            ext_dec  = EXT_SIGN;
         end
         OP_JAL: begin
            is_jal   = 1'b1;
            gpr_dec  = GPR_RA;
            wd_dec   = WD_PC4;
         end
         default: ;
      endcase
      is_ill = ~(is_rtype | is_jr | is_ori | is_addi | is_lw | is_sw | is_beq | is_jal);
   end

   // State register; reset is asynchronous and active-high
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next state and datapath controls; everything is forced low during reset
   always_comb begin
      state_nxt  = state;
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RFWr       = 1'b0;
      DMWr       = 1'b0;
      DMRd       = 1'b0;
      BSel       = 1'b0;
      WDSel      = WD_ALU;
      GPRSel     = GPR_RD;
      NPCOp      = NPC_PC4;
      EXTOp      = EXT_ZERO;
      ALUOp      = ALU_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
      if (rst_n) begin
         state_nxt = S_FETCH;
      end else begin
         if (state == S_DECODE || state == S_EXE || state == S_MEM || state == S_WB) begin
            BSel   = bsel_dec;
            WDSel  = wd_dec;
            GPRSel = gpr_dec;
            EXTOp  = ext_dec;
            ALUOp  = alu_dec;
         end
         case (state)
            S_FETCH: begin
               IRWr  = imem_ready;
               PCWr  = imem_ready;
               NPCOp = NPC_PC4;
               if (imem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
               if (is_jal) begin
                  PCWr       = 1'b1;
                  NPCOp      = NPC_J;
                  RFWr       = 1'b1;
                  instr_done = 1'b1;
                  state_nxt  = S_FETCH;
               end else if (is_jr) begin
                  PCWr       = 1'b1;
                  NPCOp      = NPC_JR;
                  instr_done = 1'b1;
                  state_nxt  = S_FETCH;
               end else if (is_ill) begin
                  illegal    = 1'b1;
                  state_nxt  = S_FETCH;
               end else begin
                  state_nxt  = S_EXE;
               end
            end
            S_EXE: begin
               if (is_beq) begin
                  PCWr       = Zero;
                  NPCOp      = NPC_BR;
                  instr_done = 1'b1;
                  state_nxt  = S_FETCH;
               end else if (is_lw || is_sw) begin
                  state_nxt  = S_MEM;
               end else begin
                  state_nxt  = S_WB;
               end
            end
            S_MEM: begin
               if (is_lw) begin
                  DMRd = 1'b1;
                  if (dmem_ready) state_nxt = S_WB;
               end else if (is_sw) begin
                  DMWr = 1'b1;
                  if (dmem_ready) begin
                     instr_done = 1'b1;
                     state_nxt  = S_FETCH;
                  end
               end else begin
                  state_nxt = S_FETCH;
               end
            end
            S_WB: begin
               RFWr       = 1'b1;
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   // Retired-instruction counter, wraps naturally at all-ones
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)           instr_cnt <= '0;
      else if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
   end

endmodule
